// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates ROB tags at dispatch, collects CDB results,
// serves operand lookups, retires in order and squashes on a mispredicted retire.
module reorder_buffer #(
  parameter int ROB_ADDR_WIDTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic                      disp_has_dest,
  input  logic [4:0]                disp_dest_reg,
  input  logic [31:0]               disp_pc,
  output logic [ROB_ADDR_WIDTH-1:0] disp_rob_tag,
  input  logic                      wb_valid,
  input  logic [ROB_ADDR_WIDTH-1:0] wb_rob_tag,
  input  logic [31:0]               wb_value,
  input  logic                      wb_mispredict,
  input  logic [31:0]               wb_target,
  input  logic [ROB_ADDR_WIDTH-1:0] lookup1_tag,
  input  logic [ROB_ADDR_WIDTH-1:0] lookup2_tag,
  output logic                      lookup1_ready,
  output logic                      lookup2_ready,
  output logic [31:0]               lookup1_value,
  output logic [31:0]               lookup2_value,
  output logic                      commit_valid,
  output logic [4:0]                commit_dest_reg,
  output logic [31:0]               commit_value,
  output logic [ROB_ADDR_WIDTH-1:0] commit_rob_tag,
  output logic                      retire_valid,
  output logic [31:0]               retire_pc,
  output logic                      flush,
  output logic [31:0]               redirect_pc,
  output logic                      rob_empty,
  output logic [ROB_ADDR_WIDTH:0]   rob_count
);

  localparam int AW    = ROB_ADDR_WIDTH;
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] has_dest_q, has_dest_d;
  logic [DEPTH-1:0] mispred_q, mispred_d;
  logic [4:0]       dest_q   [DEPTH];
  logic [4:0]       dest_d   [DEPTH];
  logic [31:0]      value_q  [DEPTH];
  logic [31:0]      value_d  [DEPTH];
  logic [31:0]      pc_q     [DEPTH];
  logic [31:0]      pc_d     [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [31:0]      target_d [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          flush_q, flush_d;
  logic [31:0]   redirect_q, redirect_d;

  logic alloc;
  logic retire;
  logic wb_accept;

  // Dispatch handshake: an entry is allocated exactly in a cycle where
  // disp_valid && disp_ready; disp_ready never depends on disp_valid.
  assign disp_ready   = (count_q != FULL_CNT) && !flush_q;
  assign disp_rob_tag = tail_q;
  assign alloc        = disp_valid && disp_ready;
  assign wb_accept    = wb_valid && valid_q[wb_rob_tag] && !flush_q;
  assign retire       = valid_q[head_q] && done_q[head_q] && !flush_q;

  assign retire_valid    = retire;
  assign retire_pc       = pc_q[head_q];
  assign commit_valid    = retire && has_dest_q[head_q] && (dest_q[head_q] != 5'd0);
  assign commit_dest_reg = dest_q[head_q];
  assign commit_value    = value_q[head_q];
  assign commit_rob_tag  = head_q;

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign rob_count   = count_q;
  assign rob_empty   = (count_q == '0);

  // Returns {ready, value}; a same-cycle CDB result wins over the stored value.
  function automatic logic [32:0] lookup(input logic [AW-1:0] tag);
    logic [32:0] res;
    res = '0;
    if (valid_q[tag]) begin
      if (wb_valid && (wb_rob_tag == tag)) res = {1'b1, wb_value};
      else if (done_q[tag])                res = {1'b1, value_q[tag]};
    end
    return res;
  endfunction

  assign {lookup1_ready, lookup1_value} = lookup(lookup1_tag);
  assign {lookup2_ready, lookup2_value} = lookup(lookup2_tag);

  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    has_dest_d = has_dest_q;
    mispred_d  = mispred_q;
    dest_d     = dest_q;
    value_d    = value_q;
    pc_d       = pc_q;
    target_d   = target_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q + {{AW{1'b0}}, alloc} - {{AW{1'b0}}, retire};
    flush_d    = 1'b0;
    redirect_d = redirect_q;

    if (wb_accept) begin
      done_d[wb_rob_tag]    = 1'b1;
      value_d[wb_rob_tag]   = wb_value;
      mispred_d[wb_rob_tag] = wb_mispredict;
      target_d[wb_rob_tag]  = wb_target;
    end

    if (alloc) begin
      valid_d[tail_q]    = 1'b1;
      done_d[tail_q]     = 1'b0;
      mispred_d[tail_q]  = 1'b0;
      has_dest_d[tail_q] = disp_has_dest;
      dest_d[tail_q]     = disp_dest_reg;
      pc_d[tail_q]       = disp_pc;
      tail_d             = tail_q + PTR_ONE;
    end

    if (retire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_ONE;
    end

    // Mispredicted head still commits above, then everything younger is
    // squashed, including a same-cycle (wrong-path) allocation.
    if (retire && mispred_q[head_q]) begin
      valid_d    = '0;
      done_d     = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      flush_d    = 1'b1;
      redirect_d = target_q[head_q];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      done_q     <= '0;
      has_dest_q <= '0;
      mispred_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i]   <= '0;
        value_q[i]  <= '0;
        pc_q[i]     <= '0;
        target_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      done_q     <= done_d;
      has_dest_q <= has_dest_d;
      mispred_q  <= mispred_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      dest_q     <= dest_d;
      value_q    <= value_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, hand sequences for full/wrap
// and reset corner cases, then random traffic against a queue-based model.
module tb_reorder_buffer;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          disp_valid, disp_ready, disp_has_dest;
  logic [4:0]    disp_dest_reg;
  logic [31:0]   disp_pc;
  logic [AW-1:0] disp_rob_tag;
  logic          wb_valid, wb_mispredict;
  logic [AW-1:0] wb_rob_tag;
  logic [31:0]   wb_value, wb_target;
  logic [AW-1:0] lookup1_tag, lookup2_tag;
  logic          lookup1_ready, lookup2_ready;
  logic [31:0]   lookup1_value, lookup2_value;
  logic          commit_valid, retire_valid, flush, rob_empty;
  logic [4:0]    commit_dest_reg;
  logic [31:0]   commit_value, retire_pc, redirect_pc;
  logic [AW-1:0] commit_rob_tag;
  logic [AW:0]   rob_count;

  reorder_buffer #(.ROB_ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_has_dest(disp_has_dest),
    .disp_dest_reg(disp_dest_reg), .disp_pc(disp_pc), .disp_rob_tag(disp_rob_tag),
    .wb_valid(wb_valid), .wb_rob_tag(wb_rob_tag), .wb_value(wb_value),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .lookup1_tag(lookup1_tag), .lookup2_tag(lookup2_tag),
    .lookup1_ready(lookup1_ready), .lookup2_ready(lookup2_ready),
    .lookup1_value(lookup1_value), .lookup2_value(lookup2_value),
    .commit_valid(commit_valid), .commit_dest_reg(commit_dest_reg),
    .commit_value(commit_value), .commit_rob_tag(commit_rob_tag),
    .retire_valid(retire_valid), .retire_pc(retire_pc),
    .flush(flush), .redirect_pc(redirect_pc),
    .rob_empty(rob_empty), .rob_count(rob_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic dv, input logic hd, input logic [4:0] rd,
                       input logic [31:0] pc, input logic wv, input logic [AW-1:0] wt,
                       input logic [31:0] wval, input logic wm, input logic [31:0] wtg,
                       input logic [AW-1:0] l1, input logic [AW-1:0] l2);
    disp_valid = dv; disp_has_dest = hd; disp_dest_reg = rd; disp_pc = pc;
    wb_valid = wv; wb_rob_tag = wt; wb_value = wval; wb_mispredict = wm; wb_target = wtg;
    lookup1_tag = l1; lookup2_tag = l2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #2;
    check("rst_count", rob_count, 0);
    check("rst_empty", rob_empty, 1);
    check("rst_ready", disp_ready, 1);
    check("rst_tag", disp_rob_tag, 0);
    check("rst_commit", commit_valid, 0);
    check("rst_retire", retire_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_redir", redirect_pc, 0);
    check("rst_lk1", lookup1_ready, 0);
    check("rst_lk2", lookup2_ready, 0);
    step();
  endtask

  // directed vector table
  typedef struct {
    logic dv; logic [4:0] rd; logic [31:0] pc;
    logic wv; logic [AW-1:0] wt; logic [31:0] wval; logic wm; logic [31:0] wtg;
    logic chk_lk; logic [AW-1:0] l1t; logic [AW-1:0] l2t;
    logic e_rdy; logic [AW-1:0] e_tag; logic e_cv; logic [4:0] e_crd; logic [31:0] e_cval;
    logic [31:0] e_rpc; logic e_fl; logic [31:0] e_redir; logic [AW:0] e_cnt;
    logic e_l1r; logic [31:0] e_l1v; logic e_l2r; logic [31:0] e_l2v;
  } row_t;
  row_t tbl[$];

  // reference model
  typedef struct {
    logic [AW-1:0] tag; logic hd; logic [4:0] rd; logic [31:0] pc;
    logic done; logic [31:0] value; logic mis; logic [31:0] tgt;
  } ent_t;
  ent_t          m_q[$];
  logic [AW-1:0] m_tag;
  logic          m_flush;
  logic [31:0]   m_redir;

  // scoreboard of expected commits {rd, value}
  logic [36:0] exp_q[$];

  function automatic logic [32:0] m_lookup(input logic [AW-1:0] tag, input logic wv,
                                           input logic [AW-1:0] wt, input logic [31:0] wval);
    foreach (m_q[k]) begin
      if (m_q[k].tag == tag) begin
        if (wv && wt == tag) return {1'b1, wval};
        if (m_q[k].done)     return {1'b1, m_q[k].value};
        return '0;
      end
    end
    return '0;
  endfunction

  initial begin
    row_t r;
    ent_t e;
    logic dv, hd, wv, wm, m_rdy, e_ret, e_cv, wb_ok;
    logic [4:0] rd;
    logic [31:0] pc, wval, wtg;
    logic [AW-1:0] wt, l1, l2;
    logic [32:0] lk;
    logic [36:0] got;

    //   dv rd    pc      wv wt wval     wm wtg     chk l1 l2  rdy tag cv crd cval     rpc     fl redir   cnt l1r l1v      l2r l2v
    r = '{1, 1, 32'h000, 0, 0, 0,       0, 0,       1, 0, 1,  1,  0, 0, 0, 0,       0,      0, 0,      0, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{1, 2, 32'h004, 0, 0, 0,       0, 0,       0, 0, 0,  1,  1, 0, 0, 0,       0,      0, 0,      1, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{1, 3, 32'h008, 0, 0, 0,       0, 0,       0, 0, 0,  1,  2, 0, 0, 0,       0,      0, 0,      2, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{0, 0, 0,       1, 2, 32'h22,  0, 0,       0, 0, 0,  1,  3, 0, 0, 0,       0,      0, 0,      3, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{0, 0, 0,       1, 0, 32'h11,  0, 0,       1, 2, 1,  1,  3, 0, 0, 0,       0,      0, 0,      3, 1, 32'h22,  0, 0}; tbl.push_back(r);
    r = '{0, 0, 0,       1, 1, 32'h33,  0, 0,       0, 0, 0,  1,  3, 1, 1, 32'h11,  32'h0,  0, 0,      3, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{0, 0, 0,       0, 0, 0,       0, 0,       0, 0, 0,  1,  3, 1, 2, 32'h33,  32'h4,  0, 0,      2, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{0, 0, 0,       0, 0, 0,       0, 0,       0, 0, 0,  1,  3, 1, 3, 32'h22,  32'h8,  0, 0,      1, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{0, 0, 0,       0, 0, 0,       0, 0,       1, 2, 0,  1,  3, 0, 0, 0,       0,      0, 0,      0, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{1, 1, 32'h100, 0, 0, 0,       0, 0,       0, 0, 0,  1,  3, 0, 0, 0,       0,      0, 0,      0, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{1, 5, 32'h104, 0, 0, 0,       0, 0,       0, 0, 0,  1,  4, 0, 0, 0,       0,      0, 0,      1, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{1, 6, 32'h108, 0, 0, 0,       0, 0,       0, 0, 0,  1,  5, 0, 0, 0,       0,      0, 0,      2, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{1, 7, 32'h10c, 0, 0, 0,       0, 0,       0, 0, 0,  1,  6, 0, 0, 0,       0,      0, 0,      3, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{0, 0, 0,       1, 5, 32'habcd,0, 0,       1, 5, 6,  1,  7, 0, 0, 0,       0,      0, 0,      4, 1, 32'habcd,0, 0}; tbl.push_back(r);
    r = '{0, 0, 0,       1, 3, 32'h104, 1, 32'h200, 1, 5, 3,  1,  7, 0, 0, 0,       0,      0, 0,      4, 1, 32'habcd,1, 32'h104}; tbl.push_back(r);
    r = '{1, 8, 32'h110, 0, 0, 0,       0, 0,       0, 0, 0,  1,  7, 1, 1, 32'h104, 32'h100,0, 0,      4, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{1, 8, 32'h110, 1, 4, 32'h55,  0, 0,       1, 4, 5,  0,  0, 0, 0, 0,       0,      1, 32'h200,0, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{1, 9, 32'h200, 0, 0, 0,       0, 0,       0, 0, 0,  1,  0, 0, 0, 0,       0,      0, 0,      0, 0, 0,       0, 0}; tbl.push_back(r);
    r = '{0, 0, 0,       0, 0, 0,       0, 0,       1, 0, 0,  1,  1, 0, 0, 0,       0,      0, 0,      1, 0, 0,       0, 0}; tbl.push_back(r);

    apply_reset();

    foreach (tbl[i]) begin
      r = tbl[i];
      drive(r.dv, 1'b1, r.rd, r.pc, r.wv, r.wt, r.wval, r.wm, r.wtg, r.l1t, r.l2t);
      #2;
      check($sformatf("row%0d_ready", i), disp_ready, r.e_rdy);
      check($sformatf("row%0d_tag", i), disp_rob_tag, r.e_tag);
      check($sformatf("row%0d_count", i), rob_count, r.e_cnt);
      check($sformatf("row%0d_empty", i), rob_empty, (r.e_cnt == 0));
      check($sformatf("row%0d_commit", i), commit_valid, r.e_cv);
      check($sformatf("row%0d_retire", i), retire_valid, r.e_cv);
      check($sformatf("row%0d_flush", i), flush, r.e_fl);
      if (r.e_cv) begin
        check($sformatf("row%0d_crd", i), commit_dest_reg, r.e_crd);
        check($sformatf("row%0d_cval", i), commit_value, r.e_cval);
        check($sformatf("row%0d_rpc", i), retire_pc, r.e_rpc);
      end
      if (r.e_fl) check($sformatf("row%0d_redir", i), redirect_pc, r.e_redir);
      if (r.chk_lk) begin
        check($sformatf("row%0d_l1r", i), lookup1_ready, r.e_l1r);
        check($sformatf("row%0d_l1v", i), lookup1_value, r.e_l1v);
        check($sformatf("row%0d_l2r", i), lookup2_ready, r.e_l2r);
        check($sformatf("row%0d_l2v", i), lookup2_value, r.e_l2v);
      end
      step();
    end

    // Fill to 16, stall, retire one while full, then wrap the tail to tag 0.
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 5'(i + 1), 32'(i * 4), 0, 0, 0, 0, 0, 0, 0);
      #2;
      check($sformatf("fill%0d_tag", i), disp_rob_tag, i);
      check($sformatf("fill%0d_ready", i), disp_ready, 1);
      step();
    end
    drive(1, 1, 5'd20, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("full_ready", disp_ready, 0);
    check("full_count", rob_count, DEPTH);
    check("full_tag", disp_rob_tag, 0);
    step();
    drive(1, 1, 5'd20, 32'h40, 1, 0, 32'ha0, 0, 0, 0, 0);
    #2;
    check("full_hold_count", rob_count, DEPTH);
    check("full_wb_commit", commit_valid, 0);
    step();
    drive(1, 1, 5'd20, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("full_ret_commit", commit_valid, 1);
    check("full_ret_value", commit_value, 32'ha0);
    check("full_ret_tag", commit_rob_tag, 0);
    check("full_ret_ready", disp_ready, 0);
    step();
    drive(1, 1, 5'd21, 32'h44, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("after_ret_ready", disp_ready, 1);
    check("after_ret_count", rob_count, DEPTH - 1);
    check("wrap_tag", disp_rob_tag, 0);
    step();
    idle();
    #2;
    check("refill_count", rob_count, DEPTH);
    check("refill_tag", disp_rob_tag, 1);
    check("refill_ready", disp_ready, 0);
    step();

    // Reset asserted while 4 entries are live and the head is a retiring mispredict.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 5'(i + 1), 32'(i * 4), 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 1, 0, 32'h77, 1, 32'h300, 0, 0);
    step();
    idle();
    #2;
    check("pre_rst_commit", commit_valid, 1);
    check("pre_rst_count", rob_count, 4);
    reset = 1'b1;
    #1;
    check("mid_rst_count", rob_count, 0);
    check("mid_rst_flush", flush, 0);
    check("mid_rst_ready", disp_ready, 1);
    check("mid_rst_commit", commit_valid, 0);
    step();
    reset = 1'b0;
    // Reset during the flush cycle itself drops the pulse at once.
    drive(1, 1, 5'd2, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 0, 32'h5, 1, 32'h400, 0, 0);
    step();
    idle();
    step();
    #1;
    check("flush_cycle", flush, 1);
    check("flush_redir", redirect_pc, 32'h400);
    reset = 1'b1;
    #1;
    check("flush_rst_flush", flush, 0);
    check("flush_rst_ready", disp_ready, 1);
    step();
    reset = 1'b0;

    // Random traffic against the queue model.
    apply_reset();
    m_q.delete();
    exp_q.delete();
    m_tag = '0;
    m_flush = 1'b0;
    m_redir = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      m_rdy = (m_q.size() != DEPTH) && !m_flush;
      dv = ($urandom_range(0, 9) < 7);
      hd = ($urandom_range(0, 3) != 0);
      rd = 5'($urandom_range(0, 31));
      pc = $urandom & 32'hffff_fffc;
      wv = ($urandom_range(0, 9) < 6);
      if (m_q.size() > 0 && $urandom_range(0, 9) < 9)
        wt = m_q[$urandom_range(0, m_q.size() - 1)].tag;
      else
        wt = AW'($urandom_range(0, DEPTH - 1));
      if (wv && dv && m_rdy && wt == m_tag) wv = 1'b0;
      wval = $urandom;
      wm = ($urandom_range(0, 29) == 0);
      wtg = $urandom & 32'hffff_fffc;
      l1 = AW'($urandom_range(0, DEPTH - 1));
      l2 = (m_q.size() > 0) ? m_q[$urandom_range(0, m_q.size() - 1)].tag
                            : AW'($urandom_range(0, DEPTH - 1));
      drive(dv, hd, rd, pc, wv, wt, wval, wm, wtg, l1, l2);
      #2;

      e_ret = (m_q.size() > 0) && m_q[0].done && !m_flush;
      e_cv  = e_ret && m_q[0].hd && (m_q[0].rd != 0);
      check("rnd_ready", disp_ready, m_rdy);
      check("rnd_tag", disp_rob_tag, m_tag);
      check("rnd_count", rob_count, m_q.size());
      check("rnd_empty", rob_empty, (m_q.size() == 0));
      check("rnd_flush", flush, m_flush);
      if (m_flush) check("rnd_redir", redirect_pc, m_redir);
      check("rnd_retire", retire_valid, e_ret);
      check("rnd_commit", commit_valid, e_cv);
      if (e_ret) begin
        check("rnd_rpc", retire_pc, m_q[0].pc);
        check("rnd_ctag", commit_rob_tag, m_q[0].tag);
      end
      if (e_cv) exp_q.push_back({m_q[0].rd, m_q[0].value});
      if (commit_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_commit", {commit_dest_reg, commit_value}, 37'h0);
        end else begin
          got = exp_q.pop_front();
          check("sb_commit", {commit_dest_reg, commit_value}, got);
        end
      end
      lk = m_lookup(l1, wv, wt, wval);
      check("rnd_l1", {lookup1_ready, lookup1_value}, lk);
      lk = m_lookup(l2, wv, wt, wval);
      check("rnd_l2", {lookup2_ready, lookup2_value}, lk);

      wb_ok = wv && !m_flush;
      if (e_ret && m_q[0].mis) begin
        m_redir = m_q[0].tgt;
        m_q.delete();
        m_tag = '0;
        m_flush = 1'b1;
      end else begin
        m_flush = 1'b0;
        if (e_ret) void'(m_q.pop_front());
        if (wb_ok) begin
          foreach (m_q[k]) begin
            if (m_q[k].tag == wt) begin
              m_q[k].done = 1'b1;
              m_q[k].value = wval;
              m_q[k].mis = wm;
              m_q[k].tgt = wtg;
            end
          end
        end
        if (dv && m_rdy) begin
          e = '{m_tag, hd, rd, pc, 1'b0, 32'h0, 1'b0, 32'h0};
          m_q.push_back(e);
          m_tag = m_tag + 1'b1;
        end
      end
      step();
    end
    check("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
